// File: rtl/stack_unit.sv
// Bus-attached LIFO unit: push/pop/peek/clear/depth over a one-request-at-a-time handshake.
// Optional feature macro: STACK_HWM_EN (high-water mark register and HWM opcode).
//
// state | meaning
// IDLE  | ready for a request, o_ready=1
// READ  | synchronous read of top entry for POP/PEEK
// RESP  | response cycle, o_valid=1
module stack_unit #(
  parameter  int DEPTH = 16,
  localparam int PTR_W = $clog2(DEPTH + 1)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_valid,
  input  logic [3:0]  i_unit_id,
  input  logic [3:0]  i_command,
  input  logic [15:0] i_data,
  output logic        o_ready,
  output logic        o_valid,
  output logic [15:0] o_data,
  output logic [3:0]  o_error,
  output logic        o_full,
  output logic        o_empty
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] DEPTH_C = PTR_W'(DEPTH);

  localparam logic [3:0] ID_STACK      = 4'h4;
  localparam logic [3:0] ERR_NONE      = 4'h0;
  localparam logic [3:0] ERR_INV_INPUT = 4'h1;

  localparam logic [3:0] CMD_NOP   = 4'd0;
  localparam logic [3:0] CMD_PUSH  = 4'd1;
  localparam logic [3:0] CMD_POP   = 4'd2;
  localparam logic [3:0] CMD_PEEK  = 4'd3;
  localparam logic [3:0] CMD_CLEAR = 4'd4;
  localparam logic [3:0] CMD_DEPTH = 4'd5;
`ifdef STACK_HWM_EN
  localparam logic [3:0] CMD_HWM   = 4'd6;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t             state;
  logic [PTR_W-1:0]   count;
  logic               pop_q;
  logic [15:0]        mem [DEPTH];

  logic               accept;
  logic               full_now;
  logic               empty_now;
  logic [ADDR_W-1:0]  wr_idx;
  logic [ADDR_W-1:0]  top_idx;

`ifdef STACK_HWM_EN
  logic [PTR_W-1:0]   hwm;
`endif

  function automatic logic [15:0] zext(input logic [PTR_W-1:0] v);
    return 16'(v);
  endfunction

  assign accept    = i_valid && o_ready && (i_unit_id == ID_STACK);
  assign full_now  = (count == DEPTH_C);
  assign empty_now = (count == '0);
  // When full, the low bits wrap to 0 and top_idx lands on DEPTH-1 as needed.
  assign wr_idx    = count[ADDR_W-1:0];
  assign top_idx   = wr_idx - ADDR_W'(1);

  // Storage has no reset; a stale top is never exposed because count gates reads.
  always_ff @(posedge clk) begin
    if (!reset && accept && (i_command == CMD_PUSH) && !full_now) begin
      mem[wr_idx] <= i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      count   <= '0;
      pop_q   <= 1'b0;
      o_ready <= 1'b1;
      o_valid <= 1'b0;
      o_data  <= '0;
      o_error <= ERR_NONE;
      o_empty <= 1'b1;
      o_full  <= 1'b0;
`ifdef STACK_HWM_EN
      hwm     <= '0;
`endif
    end else begin
      o_empty <= empty_now;
      o_full  <= full_now;
      o_valid <= 1'b0;
`ifdef STACK_HWM_EN
      if (count > hwm) hwm <= count;
`endif
      case (state)
        IDLE: begin
          if (accept) begin
            o_ready <= 1'b0;
            o_valid <= 1'b1;
            o_data  <= '0;
            o_error <= ERR_NONE;
            state   <= RESP;
            case (i_command)
              CMD_NOP: ;
              CMD_PUSH: begin
                if (!full_now) count   <= count + PTR_W'(1);
                else           o_error <= ERR_INV_INPUT;
              end
              CMD_POP, CMD_PEEK: begin
                if (!empty_now) begin
                  state   <= READ;
                  o_valid <= 1'b0;
                  pop_q   <= (i_command == CMD_POP);
                end else begin
                  o_error <= ERR_INV_INPUT;
                end
              end
              CMD_CLEAR: begin
                count  <= '0;
                o_data <= zext(count);
              end
              CMD_DEPTH: o_data <= zext(count);
`ifdef STACK_HWM_EN
              CMD_HWM:   o_data <= zext(hwm);
`endif
              default:   o_error <= ERR_INV_INPUT;
            endcase
          end
        end
        READ: begin
          o_data  <= mem[top_idx];
          o_valid <= 1'b1;
          state   <= RESP;
          if (pop_q) count <= count - PTR_W'(1);
        end
        RESP: begin
          state   <= IDLE;
          o_ready <= 1'b1;
        end
        default: begin
          state   <= IDLE;
          o_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stack_unit.sv
// Directed bench for stack_unit (DEPTH=16); define STACK_HWM_EN to exercise the HWM opcode.
module tb_stack_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_valid;
  logic [3:0]  i_unit_id;
  logic [3:0]  i_command;
  logic [15:0] i_data;
  logic        o_ready;
  logic        o_valid;
  logic [15:0] o_data;
  logic [3:0]  o_error;
  logic        o_full;
  logic        o_empty;

  localparam logic [3:0] ID_STACK = 4'h4;
  localparam logic [3:0] ID_ALU   = 4'h1;
  localparam logic [3:0] E_NONE   = 4'h0;
  localparam logic [3:0] E_INV    = 4'h1;

  int n_vec = 0;
  int n_err = 0;

  logic        got;
  int          lat;
  logic [15:0] rd;
  logic [3:0]  re;

  stack_unit #(.DEPTH(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .i_valid   (i_valid),
    .i_unit_id (i_unit_id),
    .i_command (i_command),
    .i_data    (i_data),
    .o_ready   (o_ready),
    .o_valid   (o_valid),
    .o_data    (o_data),
    .o_error   (o_error),
    .o_full    (o_full),
    .o_empty   (o_empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
    n_vec++;
    if (got_v !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got_v, exp_v);
    end
  endtask

  // Issue one request, then wait up to 5 cycles for its response.
  // On a response, idles one more cycle so the unit is back in IDLE.
  task automatic req(input logic [3:0] id, input logic [3:0] cmd, input logic [15:0] data,
                     output logic g, output int l, output logic [15:0] d, output logic [3:0] e);
    @(negedge clk);
    i_valid   = 1'b1;
    i_unit_id = id;
    i_command = cmd;
    i_data    = data;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    g = 1'b0;
    l = 0;
    d = '0;
    e = '0;
    for (int c = 1; c <= 5; c++) begin
      if (o_valid) begin
        g = 1'b1;
        l = c;
        d = o_data;
        e = o_error;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (g) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset     = 1'b1;
    i_valid   = 1'b0;
    i_unit_id = ID_STACK;
    i_command = 4'd0;
    i_data    = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(o_ready), 32'd1);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_data",  32'(o_data),  32'd0);
    chk("rst_error", 32'(o_error), 32'(E_NONE));
    chk("rst_empty", 32'(o_empty), 32'd1);
    chk("rst_full",  32'(o_full),  32'd0);
    @(negedge clk);
    reset = 1'b0;

    req(ID_STACK, 4'd5, 16'h0, got, lat, rd, re);
    chk("depth0_lat", 32'(lat), 32'd1);
    chk("depth0_data", 32'(rd), 32'd0);
    chk("depth0_err", 32'(re), 32'(E_NONE));
    chk("depth0_empty", 32'(o_empty), 32'd1);

    req(ID_STACK, 4'd1, 16'hA5A5, got, lat, rd, re);
    chk("push1_lat", 32'(lat), 32'd1);
    chk("push1_err", 32'(re), 32'(E_NONE));
    chk("push1_data", 32'(rd), 32'd0);
    req(ID_STACK, 4'd1, 16'h1234, got, lat, rd, re);
    chk("push2_err", 32'(re), 32'(E_NONE));
    req(ID_STACK, 4'd2, 16'h0, got, lat, rd, re);
    chk("pop1_lat", 32'(lat), 32'd2);
    chk("pop1_data", 32'(rd), 32'h1234);
    chk("pop1_err", 32'(re), 32'(E_NONE));
    req(ID_STACK, 4'd2, 16'h0, got, lat, rd, re);
    chk("pop2_lat", 32'(lat), 32'd2);
    chk("pop2_data", 32'(rd), 32'hA5A5);
    chk("pop2_empty", 32'(o_empty), 32'd1);

    req(ID_STACK, 4'd2, 16'h0, got, lat, rd, re);
    chk("pop_empty_lat", 32'(lat), 32'd1);
    chk("pop_empty_data", 32'(rd), 32'd0);
    chk("pop_empty_err", 32'(re), 32'(E_INV));
    req(ID_STACK, 4'd5, 16'h0, got, lat, rd, re);
    chk("pop_empty_cnt", 32'(rd), 32'd0);

    for (int i = 0; i < 16; i++) begin
      req(ID_STACK, 4'd1, 16'h0100 + 16'(i), got, lat, rd, re);
      if (i == 0)  chk("fill_empty_lag", 32'(o_empty), 32'd0);
      if (i == 14) chk("fill_not_full", 32'(o_full), 32'd0);
    end
    chk("fill_err", 32'(re), 32'(E_NONE));
    chk("full_flag", 32'(o_full), 32'd1);
    req(ID_STACK, 4'd1, 16'hDEAD, got, lat, rd, re);
    chk("push17_err", 32'(re), 32'(E_INV));
    chk("push17_full", 32'(o_full), 32'd1);
    req(ID_STACK, 4'd5, 16'h0, got, lat, rd, re);
    chk("full_cnt", 32'(rd), 32'd16);
    req(ID_STACK, 4'd2, 16'h0, got, lat, rd, re);
    chk("pop_top_full", 32'(rd), 32'h010F);
    chk("pop_top_fullflag", 32'(o_full), 32'd0);
    req(ID_STACK, 4'd4, 16'h0, got, lat, rd, re);
    chk("clear_data", 32'(rd), 32'd15);
    chk("clear_err", 32'(re), 32'(E_NONE));
    req(ID_STACK, 4'd5, 16'h0, got, lat, rd, re);
    chk("clear_cnt", 32'(rd), 32'd0);

    req(ID_STACK, 4'd1, 16'hBEEF, got, lat, rd, re);
    req(ID_STACK, 4'd1, 16'hBEEF, got, lat, rd, re);
    req(ID_STACK, 4'd3, 16'h0, got, lat, rd, re);
    chk("peek_lat", 32'(lat), 32'd2);
    chk("peek_data", 32'(rd), 32'hBEEF);
    req(ID_STACK, 4'd5, 16'h0, got, lat, rd, re);
    chk("peek_cnt", 32'(rd), 32'd2);

    req(ID_ALU, 4'd1, 16'h5555, got, lat, rd, re);
    chk("alu_id_novalid", 32'(got), 32'd0);
    req(ID_STACK, 4'd5, 16'h0, got, lat, rd, re);
    chk("alu_id_cnt", 32'(rd), 32'd2);

    // Reset while a POP sits in READ.
    @(negedge clk);
    i_valid   = 1'b1;
    i_unit_id = ID_STACK;
    i_command = 4'd2;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    reset   = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_read_valid", 32'(o_valid), 32'd0);
    chk("rst_read_ready", 32'(o_ready), 32'd1);
    chk("rst_read_empty", 32'(o_empty), 32'd1);
    @(posedge clk);
    #1;
    chk("rst_read_valid2", 32'(o_valid), 32'd0);
    req(ID_STACK, 4'd5, 16'h0, got, lat, rd, re);
    chk("rst_read_cnt", 32'(rd), 32'd0);

    req(ID_STACK, 4'hF, 16'h0, got, lat, rd, re);
    chk("badop_err", 32'(re), 32'(E_INV));
    chk("badop_data", 32'(rd), 32'd0);
    req(ID_STACK, 4'd0, 16'h0, got, lat, rd, re);
    chk("nop_err", 32'(re), 32'(E_NONE));
    chk("nop_lat", 32'(lat), 32'd1);

`ifdef STACK_HWM_EN
    for (int i = 0; i < 5; i++) req(ID_STACK, 4'd1, 16'(i), got, lat, rd, re);
    for (int i = 0; i < 3; i++) req(ID_STACK, 4'd2, 16'h0, got, lat, rd, re);
    req(ID_STACK, 4'd4, 16'h0, got, lat, rd, re);
    chk("hwm_clear_data", 32'(rd), 32'd2);
    req(ID_STACK, 4'd6, 16'h0, got, lat, rd, re);
    chk("hwm_data", 32'(rd), 32'd5);
    chk("hwm_err", 32'(re), 32'(E_NONE));
`else
    req(ID_STACK, 4'd6, 16'h0, got, lat, rd, re);
    chk("hwm_off_err", 32'(re), 32'(E_INV));
    chk("hwm_off_data", 32'(rd), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
